// File: rtl/mux4_pkg.sv
// Shared definitions for the four-way round-robin arbiter and its mux.
package mux4_pkg;

    // Number of requesters / mux inputs.
    localparam int NREQ = 4;

    // Width of the hold counter that tracks how long the current owner has held the mux.
    localparam int HOLD_W = 8;

    // Arbiter state encoding.
    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // One-hot decode of a requester index.
    function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_arbiter_rr_pick.sv
// Combinational round-robin search: starting one past the last granted
// index, return the first requester with its line set, in ascending wrap
// order. With excl set, the last granted index itself is skipped so that an
// expiring owner hands off to someone else.
module rr_pick
    import mux4_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    input  logic            excl,
    output logic [1:0]      win,
    output logic            found
);

    logic [1:0] idx;

    // Walk the wrap order from farthest to nearest so the nearest hit wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx] && !(excl && (k == NREQ))) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_arbiter.sv
// Four-way round-robin arbiter driving a 4:1 data mux. A requester keeps the
// mux while it asserts req; once others are waiting it is limited to SLOT
// consecutive cycles. Grant, select and valid are registered; the data path
// is purely combinational from the registered select.
module mux4_arbiter
    import mux4_pkg::*;
#(
    parameter int DW   = 4,
    parameter int SLOT = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ-1:0]    grant,
    output logic [1:0]         sel,
    output logic               valid,
    output logic [DW-1:0]      data
);

    state_t            state;
    logic [HOLD_W-1:0] hold;
    logic [1:0]        last;

    logic              cur_req;
    logic              others;
    logic              slot_hit;
    logic              excl;
    logic [1:0]        win;
    logic              found;

    // Hold counter increment that sticks at SLOT once reached.
    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] cnt);
        if (cnt >= HOLD_W'(SLOT)) begin
            return HOLD_W'(SLOT);
        end
        return cnt + 1'b1;
    endfunction

    // Decode what the current owner and the other requesters are asking for.
    always_comb begin
        cur_req  = req[sel];
        others   = |(req & ~onehot4(sel));
        slot_hit = (hold == HOLD_W'(SLOT));
        excl     = (state == OWN);
    end

    rr_pick u_pick (
        .req   (req),
        .last  (last),
        .excl  (excl),
        .win   (win),
        .found (found)
    );

    // Arbitration FSM with registered grant, select, valid and hold counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            grant <= '0;
            sel   <= '0;
            valid <= 1'b0;
            hold  <= '0;
            last  <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= OWN;
                        grant <= onehot4(win);
                        sel   <= win;
                        valid <= 1'b1;
                        hold  <= HOLD_W'(1);
                        last  <= win;
                    end
                end
                OWN: begin
                    if (req == '0) begin
                        // Release; sel keeps pointing at the previous owner.
                        state <= IDLE;
                        grant <= '0;
                        valid <= 1'b0;
                        hold  <= '0;
                    end else if (cur_req && !others) begin
                        hold <= sat_inc(hold);
                    end else if ((!cur_req || slot_hit) && found) begin
                        // Hand off directly to the next requester, no idle gap.
                        grant <= onehot4(win);
                        sel   <= win;
                        hold  <= HOLD_W'(1);
                        last  <= win;
                    end else begin
                        hold <= sat_inc(hold);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    valid <= 1'b0;
                    hold  <= '0;
                end
            endcase
        end
    end

    // Output mux: selected source while a grant is active, zero otherwise.
    always_comb begin
        data = '0;
        if (valid) begin
            data = din[int'(sel)*DW +: DW];
        end
    end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Randomized and directed bench for mux4_arbiter with a queue-based scoreboard.
module tb_mux4_arbiter;

    localparam int DW   = 4;
    localparam int SLOT = 8;

    logic            clk;
    logic            rstn;
    logic [3:0]      req;
    logic [4*DW-1:0] din;
    logic [3:0]      grant;
    logic [1:0]      sel;
    logic            valid;
    logic [DW-1:0]   data;

    mux4_arbiter #(.DW(DW), .SLOT(SLOT)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .req   (req),
        .din   (din),
        .grant (grant),
        .sel   (sel),
        .valid (valid),
        .data  (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] s;
        logic       v;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: owner index (-1 when idle), last granted, select, cycles held.
    int own;
    int last_m;
    int sel_m;
    int held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] mask, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        own    = -1;
        last_m = 3;
        sel_m  = 0;
        held   = 0;
    endtask

    // Advance the reference model by one clock given the request lines seen at the edge.
    task automatic model_step(input logic [3:0] r);
        logic [3:0] rest;
        exp_t e;
        if (own < 0) begin
            if (r != 0) begin
                own  = pick(r, last_m);
                held = 1;
            end
        end else begin
            rest = r & ~(4'b0001 << own);
            if (r == 0) begin
                own = -1;
            end else if (r[own] && rest == 0) begin
                held++;
            end else if (!r[own] || held >= SLOT) begin
                own  = pick(rest, last_m);
                held = 1;
            end else begin
                held++;
            end
        end
        if (own >= 0) begin
            last_m = own;
            sel_m  = own;
        end
        e.g = (own >= 0) ? (4'b0001 << own) : 4'b0000;
        e.s = 2'(sel_m);
        e.v = (own >= 0);
        q.push_back(e);
    endtask

    task automatic cycle(input logic [3:0] r);
        @(negedge clk);
        req = r;
        din = 16'($urandom);
        model_step(r);
    endtask

    task automatic release_with(input logic [3:0] r);
        @(negedge clk);
        rstn = 1'b1;
        req  = r;
        din  = 16'($urandom);
        model_step(r);
    endtask

    // Monitor: after every edge compare against the scoreboard and check invariants.
    always @(posedge clk) begin
        exp_t e;
        logic [DW-1:0] exp_d;
        #1;
        if (rstn && q.size() > 0) begin
            e = q.pop_front();
            exp_d = e.v ? din[int'(e.s)*DW +: DW] : '0;
            chk("grant", 32'(grant), 32'(e.g));
            chk("sel", 32'(sel), 32'(e.s));
            chk("valid", 32'(valid), 32'(e.v));
            chk("data", 32'(data), 32'(exp_d));
        end
        if (rstn) begin
            chk("inv_onehot", 32'($onehot0(grant)), 32'd1);
            chk("inv_grant_sel", 32'(grant[sel]), 32'(valid));
            chk("inv_valid", 32'(valid), 32'(grant != 0));
        end
    end

    initial begin
        rstn = 1'b0;
        req  = '0;
        din  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(data), 32'd0);

        // Single requester 2 after reset.
        release_with(4'b0000);
        cycle(4'b0100);
        cycle(4'b0000);
        cycle(4'b0000);

        // All requesters steady: rotation with SLOT-cycle slices.
        for (int i = 0; i < 4 * SLOT + 6; i++) cycle(4'b1111);
        cycle(4'b0000);

        // Requester 1 owns, then drops while 3 waits.
        cycle(4'b0010);
        cycle(4'b1010);
        cycle(4'b1010);
        cycle(4'b1000);
        cycle(4'b1000);
        cycle(4'b0000);

        // Lone requester 2 held for 20 cycles, then released.
        for (int i = 0; i < 20; i++) cycle(4'b0100);
        cycle(4'b0000);
        cycle(4'b0000);

        // Drop and re-raise while waiting earns no credit.
        cycle(4'b0001);
        for (int i = 0; i < 4; i++) cycle(4'b0111);
        cycle(4'b0101);
        for (int i = 0; i < 12; i++) cycle(4'b0111);
        cycle(4'b0000);

        // Asynchronous reset in the middle of a grant to requester 1.
        cycle(4'b0010);
        cycle(4'b0010);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("async_grant", 32'(grant), 32'd0);
        chk("async_valid", 32'(valid), 32'd0);
        chk("async_data", 32'(data), 32'd0);
        chk("async_queue", 32'(q.size()), 32'd0);
        q.delete();
        model_reset();
        req = 4'b0011;
        release_with(4'b0011);
        cycle(4'b0011);
        cycle(4'b0000);

        // Randomized traffic with sticky request patterns.
        for (int i = 0; i < 500; i++) begin
            logic [3:0] r;
            r = req;
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            cycle(r);
        end
        cycle(4'b0000);
        @(negedge clk);
        @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux4_arbiter.md
MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 4, meaning the data width of each source and of the output.
REQ-002 The block SHALL have parameter SLOT, default 8, legal range 2..255, meaning the maximum consecutive cycles one requester holds the mux while others wait.
REQ-003 Port clk  input  1  meaning the single system clock; all state changes occur on its rising edge.
REQ-004 Port rstn  input  1  meaning the reset; asynchronous, active-low.
REQ-005 Port req  input  4  meaning the request lines; bit i is requester i.
REQ-006 Port din  input  4*DW  meaning the packed source data; din[i*DW +: DW] is source i.
REQ-007 Port grant  output  4  meaning the registered one-hot grant; all zero when idle.
REQ-008 Port sel  output  2  meaning the registered index of the granted source, driving the 4:1 mux.
REQ-009 Port valid  output  1  meaning the registered flag that a grant is active.
REQ-010 Port data  output  DW  meaning the mux output: the selected din slice when valid=1, else all zero.

Function
REQ-011 The FSM SHALL have two states: IDLE (no grant) and OWN (one grant active).
REQ-012 In IDLE with req!=0, the block SHALL on the next edge enter OWN, grant the round-robin winner, set valid=1, and load the hold counter to 1.
REQ-013 The round-robin search SHALL start at index (last+1) mod 4, where last is the most recently granted index (3 after reset), and SHALL take the first set req bit in ascending wrap order.
REQ-014 In OWN, while req[sel]=1 and no other req bit is set, the grant SHALL persist indefinitely, with the hold counter saturating at SLOT.
REQ-015 In OWN, when req[sel]=1, another req bit is set, and the hold counter equals SLOT, the grant SHALL move on the next edge to the round-robin winner among the other requesters, with the counter reloaded to 1.
REQ-016 In OWN, when req[sel]=0 and another req bit is set, the grant SHALL move on the next edge to the round-robin winner, with no idle gap cycle.
REQ-017 In OWN, when req=0, the block SHALL return to IDLE on the next edge with grant=0 and valid=0; sel SHALL hold its last value.
REQ-018 Otherwise in OWN, the hold counter SHALL increment by 1 per cycle.
REQ-019 Grant latency SHALL be exactly one cycle from a qualifying req change to the grant change.
REQ-020 grant SHALL be one-hot or zero in every cycle, grant[sel] SHALL equal valid, and valid SHALL equal (grant!=0).
REQ-021 data SHALL be a combinational function of the registered sel and valid and of din; it SHALL have no added latency relative to din.
REQ-022 A requester that drops and re-raises req while not granted SHALL keep no priority credit; priority SHALL depend only on last.

Reset
REQ-023 While rstn=0, the block SHALL asynchronously force: state=IDLE, grant=0, sel=0, valid=0, hold counter=0, last=3.
REQ-024 Assertion of rstn mid-grant SHALL drop the grant immediately, without waiting for a clock edge.
REQ-025 On the first rising clk edge after rstn deasserts, the block SHALL evaluate req per REQ-012.

Structure
REQ-026 Shared package mux4_pkg SHALL hold the state encoding constants (IDLE, OWN) and NREQ=4.
REQ-027 Sub-module rr_pick SHALL be combinational and SHALL map (req, last, exclude-current flag) to a winner index and a found flag.
REQ-028 The hold counter SHALL be 8 bits wide.

Verification
REQ-029 Scenario: reset with req=4'b0000, then req=4'b0100 -> one cycle later grant=4'b0100, sel=2, valid=1, and data equals din slice 2.
REQ-030 Scenario: all requesters steady at req=4'b1111 with SLOT=8 -> the grant rotates 0,1,2,3,0, each held exactly 8 cycles.
REQ-031 Scenario: requester 1 is granted and drops req while req[3]=1 -> the next cycle grant=4'b1000 with no gap.
REQ-032 Scenario: a single requester 2 holds req for 20 cycles -> grant=4'b0100 for all 20 cycles (no forced release); req drops -> the next cycle valid=0 and data=0.
REQ-033 Scenario: rstn is pulsed low mid-cycle while grant=4'b0010 -> grant=0 and valid=0 immediately; after release with req=4'b0011, the first grant is 4'b0001 (last=3).
REQ-034 The bench SHALL check the invariants of REQ-020 every cycle.
